sram_stream_reader: RTL

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

---
 rtl/sram_stream_reader_if.sv | 28 ++
 rtl/sram_stream_reader.sv | 86 ++++++++
 2 files changed

// File: rtl/sram_stream_reader_if.sv
// sram_stream_reader_if: control, SRAM read port and output stream of the reader
// SRAM_RD_ABORT_EN adds the abort input.
interface sram_stream_reader_if #(parameter int WIDTH = 64, parameter int DEPTH = 256);
  localparam int AW = $clog2(DEPTH);
  logic start;
  logic [AW-1:0] base_addr;
  logic [AW:0] len;
  logic busy;
  logic done;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic m_valid;
  logic m_ready;
  logic [WIDTH-1:0] m_data;
`ifdef SRAM_RD_ABORT_EN
  logic abort;
  modport master(input start, base_addr, len, mem_rdata, m_ready, abort,
                 output busy, done, mem_we, mem_addr, m_valid, m_data);
  modport slave(output start, base_addr, len, mem_rdata, m_ready, abort,
                input busy, done, mem_we, mem_addr, m_valid, m_data);
`else
  modport master(input start, base_addr, len, mem_rdata, m_ready,
                 output busy, done, mem_we, mem_addr, m_valid, m_data);
  modport slave(output start, base_addr, len, mem_rdata, m_ready,
                input busy, done, mem_we, mem_addr, m_valid, m_data);
`endif
endinterface

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: reads len words from a 1-cycle-latency SRAM into a 2-entry FIFO-backed stream
// SRAM_RD_ABORT_EN enables the abort input.
module sram_stream_reader #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic rst_n,
  sram_stream_reader_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] nxt, last;
  logic [AW:0] rem, left;
  logic inflight, wp, rp, hs, issue, kill, fin;
  logic [1:0] cnt, occ;
  logic [WIDTH-1:0] fifo [2];
`ifdef SRAM_RD_ABORT_EN
  assign kill = bus.abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  assign hs = bus.m_valid && bus.m_ready;
  // occupancy the FIFO will hold after this edge, counting the read already in flight
  assign occ = cnt + {1'b0, inflight} - {1'b0, hs};
  assign issue = state == READ && occ < 2'd2;
  assign fin = state == DRAIN && hs && left == ONE;
  assign bus.mem_addr = issue ? nxt : last;
  assign bus.mem_we = 1'b0;
  assign bus.busy = state != IDLE;
  assign bus.m_valid = cnt != 2'd0;
  assign bus.m_data = fifo[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = kill ? IDLE :
              state == IDLE && bus.start && bus.len != '0 ? READ :
              issue && rem == ONE ? DRAIN :
              fin ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done <= 1'b0;
      nxt <= '0;
      last <= '0;
      rem <= '0;
      left <= '0;
      inflight <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      bus.done <= kill || fin || (state == IDLE && bus.start && bus.len == '0);
      if (state == IDLE && bus.start) begin
        nxt <= bus.base_addr;
        rem <= bus.len;
        left <= bus.len;
      end
      if (issue) begin
        last <= nxt;
        nxt <= nxt == AW'(DEPTH - 1) ? '0 : nxt + 1'b1;
        rem <= rem - 1'b1;
      end
      if (hs) left <= left - 1'b1;
      if (kill) begin
        inflight <= 1'b0;
        wp <= 1'b0;
        rp <= 1'b0;
        cnt <= 2'd0;
      end else begin
        inflight <= issue;
        if (inflight) begin
          fifo[wp] <= bus.mem_rdata;
          wp <= ~wp;
        end
        if (hs) rp <= ~rp;
        cnt <= occ;
      end
    end
  end
endmodule
